ps2_link: RTL and testbench

//  Bidirectional PS/2 physical-layer transceiver that sits directly below the PS/2 mouse/keyboard handlers.
//  - Debounces the open-collector clock and data lines.
//  - Deserialises device-to-host frames into bytes.
//  - Serialises host-to-device commands, including the inhibit/request-to-send sequence and the ACK check.
//  - Presents a byte/level handshake that the handlers sample with a rising-edge strobe.

---
 rtl/ps2_link_pkg.sv | 35 +++
 rtl/ps2_link_deb.sv | 43 ++++
 rtl/ps2_link.sv | 232 +++++++++++++++++++++++
 tb/tb_ps2_link.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_link_pkg.sv
// ps2_link_pkg: shared types and protocol constants for the PS/2 link.
//   state_t    - transceiver FSM states
//   CMD_*      - host-to-device command bytes
//   RSP_*      - device-to-host response bytes
//   FRAME_LEN  - bits in one device-to-host frame (start, 8 data, parity, stop)
//   frame_bad  - frame check: start must be 0, stop must be 1, data+parity odd
package ps2_link_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_INHIBIT,
    S_REQ,
    S_TX_BITS,
    S_TX_ACK,
    S_TX_DONE
  } state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_DISABLE  = 8'hF5;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  localparam int FRAME_LEN = 11;

  // f[0] is the start bit, f[FRAME_LEN-1] the stop bit, f[9:1] data plus parity.
  function automatic logic frame_bad(input logic [FRAME_LEN-1:0] f);
    return f[0] | ~f[FRAME_LEN-1] | ~(^f[FRAME_LEN-2:1]);
  endfunction

endpackage

// File: rtl/ps2_link_deb.sv
// ps2_link_deb: 2-FF synchroniser followed by a stability filter.
//   clock  in  system clock
//   reset  in  asynchronous reset, active low
//   in     in  raw (asynchronous) line level
//   out    out filtered level; follows the synchronised input once it has
//              held the same value for 2^DEB_SIZE cycles; resets to 1
module ps2_link_deb #(
  parameter int DEB_SIZE = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic                sync_p0;
  logic                sync_p1;
  logic                prev;
  logic [DEB_SIZE-1:0] cnt;

  // Idle bus level is high, so the whole chain resets to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev    <= 1'b1;
      cnt     <= '0;
      out     <= 1'b1;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
      prev    <= sync_p1;
      if (sync_p1 != prev) begin
        cnt <= '0;
      end else if (&cnt) begin
        out <= prev;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_link.sv
// ps2_link: bidirectional PS/2 physical-layer transceiver.
//   clock         in     system clock
//   reset         in     asynchronous reset, active low
//   tx_ena        in     request to send tx_cmd (sampled in IDLE only)
//   tx_cmd        in  9  {odd parity, byte}, sent exactly as given
//   tx_busy       out    high from acceptance until ACK sampled or abort
//   ack_error     out    device NAK or watchdog expiry on the last transmission
//   ps2_code      out 8  last received byte
//   ps2_code_new  out    low while a received frame is in flight, high otherwise
//   rx_error      out    last received frame failed its check or was truncated
//   ps2_clk       inout  open-collector clock, only ever driven low
//   ps2_data      inout  open-collector data, only ever driven low
module ps2_link
  import ps2_link_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEB_SIZE = 8,
  parameter int TMO_MS   = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_ena,
  input  logic [8:0] tx_cmd,
  output logic       tx_busy,
  output logic       ack_error,
  output logic [7:0] ps2_code,
  output logic       ps2_code_new,
  output logic       rx_error,
  inout  wire        ps2_clk,
  inout  wire        ps2_data
);

  localparam int INHIBIT_CNT = CLK_FREQ / 10_000;        // 100us
  localparam int IDLE_CNT    = CLK_FREQ / 18_000;        // 55us
  localparam int WD_CNT      = CLK_FREQ / 1000 * TMO_MS;

  localparam int INH_W  = (INHIBIT_CNT > 1) ? $clog2(INHIBIT_CNT) : 1;
  localparam int IDLE_W = (IDLE_CNT > 1)    ? $clog2(IDLE_CNT)    : 1;
  localparam int WD_W   = (WD_CNT > 1)      ? $clog2(WD_CNT)      : 1;

  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CNT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CNT - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WD_CNT - 1);

  localparam logic [3:0] RX_FULL = 4'(FRAME_LEN);
  // Host frame is 8 data + parity + stop = 10 device edges; index of the last.
  localparam logic [3:0] TX_LAST = 4'(FRAME_LEN - 2);

  state_t state, state_nxt;

  logic                 clk_deb, data_deb, clk_prev;
  logic                 fall;
  logic                 clk_low, data_low;
  logic [3:0]           bit_cnt;
  logic [INH_W-1:0]     inh_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic [FRAME_LEN-1:0] rx_sr;
  logic [9:0]           tx_sr;
  logic                 inh_done, idle_done, in_tx, wd_expire;
  logic                 rx_take, tx_accept, tx_shift;

  ps2_link_deb #(.DEB_SIZE(DEB_SIZE)) u_deb_clk (
    .clock (clock),
    .reset (reset),
    .in    (ps2_clk),
    .out   (clk_deb)
  );

  ps2_link_deb #(.DEB_SIZE(DEB_SIZE)) u_deb_data (
    .clock (clock),
    .reset (reset),
    .in    (ps2_data),
    .out   (data_deb)
  );

  assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = data_low ? 1'b0 : 1'bz;

  assign fall      = clk_prev & ~clk_deb;
  assign inh_done  = (inh_cnt == INH_LAST);
  assign idle_done = clk_deb && (idle_cnt == IDLE_LAST);
  assign in_tx     = (state == S_REQ) || (state == S_TX_BITS) || (state == S_TX_ACK);
  assign wd_expire = in_tx && !fall && (wd_cnt == WD_LAST);
  assign tx_accept = (state == S_IDLE) && tx_ena;
  assign tx_shift  = (state == S_TX_BITS) && fall;
  // Transmit wins over a coincident clock edge; edges past a full frame are dropped.
  assign rx_take   = fall && (((state == S_IDLE) && !tx_ena) ||
                              ((state == S_RX) && (bit_cnt != RX_FULL)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clk_low   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_ena) begin
          state_nxt = S_INHIBIT;
        end else if (fall) begin
          state_nxt = S_RX;
        end
      end
      S_RX: begin
        if (idle_done) state_nxt = S_IDLE;
      end
      S_INHIBIT: begin
        clk_low = 1'b1;
        if (inh_done) state_nxt = S_REQ;
      end
      S_REQ: begin
        state_nxt = wd_expire ? S_IDLE : S_TX_BITS;
      end
      S_TX_BITS: begin
        if (wd_expire) begin
          state_nxt = S_IDLE;
        end else if (fall && (bit_cnt == TX_LAST)) begin
          state_nxt = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (wd_expire) begin
          state_nxt = S_IDLE;
        end else if (fall) begin
          state_nxt = S_TX_DONE;
        end
      end
      S_TX_DONE: begin
        if (clk_deb && data_deb) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_prev     <= 1'b1;
      tx_busy      <= 1'b0;
      ack_error    <= 1'b0;
      ps2_code     <= '0;
      ps2_code_new <= 1'b1;
      rx_error     <= 1'b0;
      data_low     <= 1'b0;
      bit_cnt      <= '0;
      inh_cnt      <= '0;
      idle_cnt     <= '0;
      wd_cnt       <= '0;
    end else begin
      clk_prev <= clk_deb;
      case (state)
        S_IDLE: begin
          inh_cnt  <= '0;
          idle_cnt <= '0;
          if (tx_accept) begin
            tx_busy   <= 1'b1;
            ack_error <= 1'b0;
          end else if (fall) begin
            ps2_code_new <= 1'b0;
            bit_cnt      <= 4'd1;
          end
        end
        S_RX: begin
          if (!clk_deb) begin
            idle_cnt <= '0;
          end else if (!idle_done) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (rx_take) bit_cnt <= bit_cnt + 1'b1;
          if (idle_done) begin
            ps2_code_new <= 1'b1;
            if (bit_cnt == RX_FULL) begin
              ps2_code <= rx_sr[8:1];
              rx_error <= frame_bad(rx_sr);
            end else begin
              rx_error <= 1'b1;
            end
          end
        end
        S_INHIBIT: begin
          if (!inh_done) begin
            inh_cnt <= inh_cnt + 1'b1;
          end else begin
            // Start bit goes low on the same cycle the clock is released.
            data_low <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        S_TX_BITS: begin
          if (fall) begin
            data_low <= ~tx_sr[0];
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        S_TX_ACK: begin
          if (fall) ack_error <= data_deb;
        end
        S_TX_DONE: begin
          if (clk_deb && data_deb) tx_busy <= 1'b0;
        end
        default: ;
      endcase

      if (in_tx && !fall && !wd_expire) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end

      if (wd_expire) begin
        data_low  <= 1'b0;
        ack_error <= 1'b1;
        tx_busy   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rx_take) rx_sr <= {data_deb, rx_sr[FRAME_LEN-1:1]};
    if (tx_accept) begin
      tx_sr <= {1'b1, tx_cmd};
    end else if (tx_shift) begin
      tx_sr <= {1'b0, tx_sr[9:1]};
    end
  end

endmodule

// File: tb/tb_ps2_link.sv
// tb_ps2_link: self-checking bench for ps2_link with a simple device model.
// Runs the DUT at a scaled-down clock (1 MHz, 4-cycle debounce, 1 ms watchdog)
// so every protocol phase fits in a short run; the device clocks at 40 cycles/bit.
module tb_ps2_link;
  import ps2_link_pkg::*;

  localparam int CLK_FREQ = 1_000_000;
  localparam int DEB_SIZE = 2;
  localparam int TMO_MS   = 1;
  localparam int H        = 20;                  // device half clock period
  localparam int INH      = CLK_FREQ / 10_000;   // 100 cycles of inhibit
  localparam int WD       = CLK_FREQ / 1000 * TMO_MS;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tx_ena = 1'b0;
  logic [8:0] tx_cmd = '0;
  logic       tx_busy, ack_error, ps2_code_new, rx_error;
  logic [7:0] ps2_code;
  wire        ps2_clk, ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;

  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_data);

  always #5 clock = ~clock;

  ps2_link #(.CLK_FREQ(CLK_FREQ), .DEB_SIZE(DEB_SIZE), .TMO_MS(TMO_MS)) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_ena       (tx_ena),
    .tx_cmd       (tx_cmd),
    .tx_busy      (tx_busy),
    .ack_error    (ack_error),
    .ps2_code     (ps2_code),
    .ps2_code_new (ps2_code_new),
    .rx_error     (rx_error),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start;
    logic       stop;
    logic       exp_err;
  } rx_vec_t;

  typedef struct {
    logic [8:0] cmd;
    logic       ack;
    logic       exp_nak;
  } tx_vec_t;

  rx_vec_t rxv [6];
  tx_vec_t txv [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Device-to-host frame, bit 0 first; data changes mid-high, host sees the falling edge.
  task automatic send_frame(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      dev_data_low = ~bits[i];
      cycles(H/2);
      dev_clk_low = 1'b1;
      cycles(H);
      if (i == 0) check("code_new low in frame", ps2_code_new, 1'b0);
      dev_clk_low = 1'b0;
      cycles(H/2);
    end
    dev_data_low = 1'b0;
  endtask

  // ps2_code_new rises 55 idle counts after the debounced clock settles high.
  task automatic wait_frame_done(input string name);
    int n;
    n = 0;
    while (ps2_code_new !== 1'b1 && n < 400) begin
      n++;
      @(negedge clock);
    end
    check_range(name, n, 46, 58);
  endtask

  task automatic do_tx(input logic [8:0] cmd, input logic ack, input logic exp_nak);
    int n;
    logic [9:0] got;
    @(negedge clock);
    tx_cmd = cmd;
    tx_ena = 1'b1;
    @(negedge clock);
    tx_ena = 1'b0;
    check("tx_busy after accept", tx_busy, 1'b1);
    check("ack_error cleared on accept", ack_error, 1'b0);
    n = 0;
    while (ps2_clk === 1'b0 && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check_range("inhibit length", n, INH - 1, INH + 1);
    check("start bit on data", ps2_data, 1'b0);
    cycles(H);
    got = '0;
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      cycles(H);
      dev_clk_low = 1'b0;
      cycles(H/2);
      got[i] = ps2_data;
      cycles(H/2);
    end
    check("tx frame bits", got, {1'b1, cmd});
    dev_data_low = ~ack;
    cycles(H/2);
    dev_clk_low = 1'b1;
    cycles(H);
    dev_clk_low = 1'b0;
    cycles(H/2);
    dev_data_low = 1'b0;
    n = 0;
    while (tx_busy === 1'b1 && n < 500) begin
      n++;
      @(negedge clock);
    end
    check("tx_busy falls after ack", tx_busy, 1'b0);
    check("ack_error", ack_error, exp_nak);
  endtask

  initial begin
    int n;
    int lows;

    // FA: six ones, parity 1 -> odd. AA: four ones, so parity 0 is even (bad).
    rxv[0] = '{RSP_ACK,      1'b1, 1'b0, 1'b1, 1'b0};
    rxv[1] = '{RSP_BAT_OK,   1'b0, 1'b0, 1'b1, 1'b1};
    rxv[2] = '{RSP_BAT_OK,   1'b1, 1'b0, 1'b1, 1'b0};
    rxv[3] = '{RSP_RESEND,   1'b0, 1'b0, 1'b1, 1'b0};
    rxv[4] = '{CMD_ENABLE,   1'b0, 1'b1, 1'b1, 1'b1};   // start bit high
    rxv[5] = '{CMD_SET_LEDS, 1'b1, 1'b0, 1'b0, 1'b1};   // stop bit low

    txv[0] = '{{1'b1, CMD_RESET},    1'b0, 1'b0};
    txv[1] = '{{1'b0, CMD_ENABLE},   1'b1, 1'b1};
    txv[2] = '{{1'b1, CMD_SET_LEDS}, 1'b0, 1'b0};

    cycles(5);
    check("reset tx_busy", tx_busy, 1'b0);
    check("reset ack_error", ack_error, 1'b0);
    check("reset ps2_code", ps2_code, 8'h00);
    check("reset ps2_code_new", ps2_code_new, 1'b1);
    check("reset rx_error", rx_error, 1'b0);
    check("reset ps2_clk released", ps2_clk, 1'b1);
    check("reset ps2_data released", ps2_data, 1'b1);
    reset = 1'b1;
    cycles(30);

    for (int k = 0; k < 6; k++) begin
      send_frame({1'b1, rxv[k].stop, rxv[k].par, rxv[k].data, rxv[k].start}, 11);
      wait_frame_done("rx frame done latency");
      check("rx ps2_code", ps2_code, rxv[k].data);
      check("rx rx_error", rx_error, rxv[k].exp_err);
      cycles(40);
    end

    // Twelve edges: the extra one is ignored and the first eleven form the byte.
    send_frame({1'b0, 1'b1, 1'b1, RSP_ACK, 1'b0}, 12);
    wait_frame_done("excess edge frame latency");
    check("excess edge ps2_code", ps2_code, RSP_ACK);
    check("excess edge rx_error", rx_error, 1'b0);
    cycles(40);

    // Short clock glitch in IDLE must not start a frame.
    @(negedge clock);
    dev_clk_low = 1'b1;
    cycles(2);
    dev_clk_low = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ps2_code_new !== 1'b1) lows++;
    end
    check("glitch code_new low cycles", lows, 0);
    check("glitch rx_error", rx_error, 1'b0);
    check("glitch ps2_code", ps2_code, RSP_ACK);

    // Truncated six-edge frame: flagged, previous byte kept.
    send_frame({1'b1, 1'b1, 1'b1, 8'h12, 1'b0}, 6);
    wait_frame_done("truncated frame latency");
    check("truncated rx_error", rx_error, 1'b1);
    check("truncated ps2_code kept", ps2_code, RSP_ACK);
    cycles(40);

    for (int k = 0; k < 3; k++) begin
      do_tx(txv[k].cmd, txv[k].ack, txv[k].exp_nak);
      cycles(40);
    end

    // Silent device: watchdog aborts 100 inhibit + 1000 watchdog cycles after accept.
    @(negedge clock);
    tx_cmd = {1'b0, CMD_ENABLE};
    tx_ena = 1'b1;
    @(negedge clock);
    tx_ena = 1'b0;
    n = 0;
    while (tx_busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clock);
    end
    check_range("watchdog abort time", n, INH + WD - 5, INH + WD + 5);
    check("watchdog ack_error", ack_error, 1'b1);
    check("watchdog ps2_data released", ps2_data, 1'b1);
    check("watchdog ps2_clk released", ps2_clk, 1'b1);
    cycles(40);

    // Reset during TX_BITS while the host holds data low.
    @(negedge clock);
    tx_cmd = {1'b1, CMD_SET_LEDS};
    tx_ena = 1'b1;
    @(negedge clock);
    tx_ena = 1'b0;
    n = 0;
    while (ps2_clk !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check_range("inhibit before reset", n, INH - 1, INH + 1);
    cycles(H);
    for (int i = 0; i < 2; i++) begin
      dev_clk_low = 1'b1;
      cycles(H);
      dev_clk_low = 1'b0;
      cycles(H/2);
    end
    cycles(10);
    check("data driven before reset", ps2_data, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mid-tx reset ps2_data", ps2_data, 1'b1);
    check("mid-tx reset ps2_clk", ps2_clk, 1'b1);
    check("mid-tx reset tx_busy", tx_busy, 1'b0);
    check("mid-tx reset ps2_code_new", ps2_code_new, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    cycles(30);
    do_tx({1'b1, CMD_DISABLE}, 1'b0, 1'b0);
    cycles(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
